// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv32_pkg                                                    |
// | Brief  : Shared types for the rv32 memory arbiter (state, grant).    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package rv32_pkg;

    localparam int c_XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/rv32_arb_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv32_arb_prio                                               |
// | Brief  : Fetch/data grant select with data-streak starvation guard.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rv32_arb_prio
    import rv32_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   idle,
    output grant_e grant
);

    localparam int c_STREAK_W = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_SAT = c_STREAK_W'(STREAK_MAX);

    logic [c_STREAK_W-1:0] r_streak;
    logic                  w_sat;

    assign w_sat = (r_streak == c_STREAK_SAT);

    // Data wins a tie unless fetch has already waited through a full streak.
    always_comb begin
        grant = GNT_IF;
        if (dm_req && !(if_req && w_sat)) begin
            grant = GNT_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (idle && (if_req || dm_req)) begin
            if (grant == GNT_IF) begin
                r_streak <= '0;
            end else if (if_req && !w_sat) begin
                r_streak <= r_streak + c_STREAK_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv32_mem_arb                                                |
// | Brief  : Single-port memory arbiter between fetch and data ports.    |
// |          Define ARB_TIMEOUT_EN to enable the ack-wait timeout.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rv32_mem_arb
    import rv32_pkg::*;
#(
    parameter int XLEN           = c_XLEN_DEFAULT,
    parameter int STREAK_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ready,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            err
);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    grant_e          w_grant;
    logic            w_idle;
    logic            w_busy;
    logic            w_any_req;
    logic            w_timeout;
    logic            w_finish;
    logic            r_mem_req;
    logic            r_mem_we;
    logic            r_if_ready;
    logic            r_dm_ready;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_dm_rdata;

    assign w_idle    = (r_state == IDLE);
    assign w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_DM);
    assign w_any_req = if_req || dm_req;
    assign w_finish  = w_busy && (mem_ack || w_timeout);

    rv32_arb_prio #(
        .STREAK_MAX (STREAK_MAX)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .dm_req (dm_req),
        .idle   (w_idle),
        .grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = (w_grant == GNT_DM) ? BUSY_DM : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (w_finish) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready pulses default low; a timed-out transaction returns zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            if (w_idle && w_any_req) begin
                r_mem_req <= 1'b1;
                if (w_grant == GNT_DM) begin
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                end
            end
            if (w_finish) begin
                r_mem_req <= 1'b0;
                if (r_state == BUSY_IF) begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    r_dm_ready <= 1'b1;
                    r_dm_rdata <= mem_ack ? mem_rdata : '0;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMR_W-1:0] r_timer;
    logic               r_err;

    // Timer reads 0 in the first BUSY cycle; an ack in the final cycle wins.
    assign w_timeout = w_busy && !mem_ack && (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_timeout;
            r_timer <= w_busy ? (r_timer + c_TMR_W'(1)) : '0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall     = (if_req && !r_if_ready) || (dm_req && !r_dm_ready);

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_rv32_mem_arb                                             |
// | Brief  : Directed cycle-table and sequence bench for rv32_mem_arb.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_rv32_mem_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int ngnt;
    logic prev_req;

    always #5 clk = ~clk;

    rv32_mem_arb #(
        .XLEN           (32),
        .STREAK_MAX     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .err       (err)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] mrdata;
        logic        xmreq;
        logic        xmwe;
        logic [31:0] xmaddr;
        logic [31:0] xmwdata;
        logic        xirdy;
        logic [31:0] xirdata;
        logic        xdrdy;
        logic [31:0] xdrdata;
        logic        xstall;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dwe,
        input logic [31:0] daddr, input logic [31:0] dwdata, input logic ack,
        input logic [31:0] mrdata, input logic xmreq, input logic xmwe,
        input logic [31:0] xmaddr, input logic [31:0] xmwdata, input logic xirdy,
        input logic [31:0] xirdata, input logic xdrdy, input logic [31:0] xdrdata,
        input logic xstall);
        vec_t v;
        v.ireq = ireq;   v.iaddr = iaddr;   v.dreq = dreq;     v.dwe = dwe;
        v.daddr = daddr; v.dwdata = dwdata; v.ack = ack;       v.mrdata = mrdata;
        v.xmreq = xmreq; v.xmwe = xmwe;     v.xmaddr = xmaddr; v.xmwdata = xmwdata;
        v.xirdy = xirdy; v.xirdata = xirdata; v.xdrdy = xdrdy; v.xdrdata = xdrdata;
        v.xstall = xstall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fetch-only, simultaneous store+fetch, back-to-back loads, ack in IDLE.
        vecs[0]  = mk(1,'h100,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,1);
        vecs[1]  = mk(1,'h100,0,0,0,0,0,0,                      1,0,'h100,0,0,0,0,0,1);
        vecs[2]  = mk(1,'h100,0,0,0,0,0,0,                      1,0,'h100,0,0,0,0,0,1);
        vecs[3]  = mk(1,'h100,0,0,0,0,1,'h00500093,             1,0,'h100,0,0,0,0,0,1);
        vecs[4]  = mk(1,'h100,0,0,0,0,0,0,                      0,0,'h100,0,1,'h00500093,0,0,0);
        vecs[5]  = mk(0,0,0,0,0,0,0,0,                          0,0,'h100,0,0,'h00500093,0,0,0);
        vecs[6]  = mk(1,'h104,1,1,'h200,'hDEADBEEF,0,0,         0,0,'h100,0,0,'h00500093,0,0,1);
        vecs[7]  = mk(1,'h104,1,1,'h200,'hDEADBEEF,1,'h11111111, 1,1,'h200,'hDEADBEEF,0,'h00500093,0,0,1);
        vecs[8]  = mk(1,'h104,1,1,'h200,'hDEADBEEF,0,0,         0,1,'h200,'hDEADBEEF,0,'h00500093,1,'h11111111,1);
        vecs[9]  = mk(1,'h104,0,0,0,0,0,0,                      0,1,'h200,'hDEADBEEF,0,'h00500093,0,'h11111111,1);
        vecs[10] = mk(1,'h104,0,0,0,0,1,'h00A00113,             1,0,'h104,0,0,'h00500093,0,'h11111111,1);
        vecs[11] = mk(1,'h104,0,0,0,0,0,0,                      0,0,'h104,0,1,'h00A00113,0,'h11111111,0);
        vecs[12] = mk(0,0,0,0,0,0,0,0,                          0,0,'h104,0,0,'h00A00113,0,'h11111111,0);
        vecs[13] = mk(0,0,1,0,'h10,0,0,0,                       0,0,'h104,0,0,'h00A00113,0,'h11111111,1);
        vecs[14] = mk(0,0,1,0,'h10,0,1,'hAAAA0001,              1,0,'h10,0,0,'h00A00113,0,'h11111111,1);
        vecs[15] = mk(0,0,1,0,'h10,0,0,0,                       0,0,'h10,0,0,'h00A00113,1,'hAAAA0001,0);
        vecs[16] = mk(0,0,1,0,'h14,0,0,0,                       0,0,'h10,0,0,'h00A00113,0,'hAAAA0001,1);
        vecs[17] = mk(0,0,1,0,'h14,0,1,'hBBBB0002,              1,0,'h14,0,0,'h00A00113,0,'hAAAA0001,1);
        vecs[18] = mk(0,0,1,0,'h14,0,0,0,                       0,0,'h14,0,0,'h00A00113,1,'hBBBB0002,0);
        vecs[19] = mk(0,0,0,0,0,0,1,'hCCCC0003,                 0,0,'h14,0,0,'h00A00113,0,'hBBBB0002,0);
        vecs[20] = mk(0,0,0,0,0,0,0,0,                          0,0,'h14,0,0,'h00A00113,0,'hBBBB0002,0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);

        // Cycle table
        for (int r = 0; r < NVEC; r++) begin
            tick();
            if_req = vecs[r].ireq;   if_addr = vecs[r].iaddr;
            dm_req = vecs[r].dreq;   dm_we = vecs[r].dwe;
            dm_addr = vecs[r].daddr; dm_wdata = vecs[r].dwdata;
            mem_ack = vecs[r].ack;   mem_rdata = vecs[r].mrdata;
            #1;
            chk($sformatf("row%0d_mem_req", r), mem_req, vecs[r].xmreq);
            chk($sformatf("row%0d_mem_we", r), mem_we, vecs[r].xmwe);
            chk($sformatf("row%0d_mem_addr", r), mem_addr, vecs[r].xmaddr);
            chk($sformatf("row%0d_mem_wdata", r), mem_wdata, vecs[r].xmwdata);
            chk($sformatf("row%0d_if_ready", r), if_ready, vecs[r].xirdy);
            chk($sformatf("row%0d_if_rdata", r), if_rdata, vecs[r].xirdata);
            chk($sformatf("row%0d_dm_ready", r), dm_ready, vecs[r].xdrdy);
            chk($sformatf("row%0d_dm_rdata", r), dm_rdata, vecs[r].xdrdata);
            chk($sformatf("row%0d_stall", r), stall, vecs[r].xstall);
            chk($sformatf("row%0d_err", r), err, 0);
        end

        // Starvation guard: with both held, grants go D D D D I D D D D I
        tick();
        drive_idle();
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_addr = 32'h400;
        ngnt = 0;
        prev_req = 1'b0;
        for (int c = 0; c < 200 && ngnt < 10; c++) begin
            tick();
            mem_ack = mem_req;
            if (mem_req && !prev_req) begin
                chk($sformatf("starve_grant%0d_addr", ngnt), mem_addr,
                    ((ngnt % 5) == 4) ? 32'h300 : 32'h400);
                ngnt++;
            end
            prev_req = mem_req;
        end
        chk("starve_grant_count", ngnt, 10);
        tick();
        drive_idle();
        tick();
        tick();

        // Reset while BUSY_DM aborts the store; a later ack is ignored
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h12345678;
        tick();
        #1;
        chk("rstmid_busy_req", mem_req, 1);
        chk("rstmid_busy_we", mem_we, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dm_req = 1'b0;
        #1;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_dm_ready", dm_ready, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rstmid_late_ack_req", mem_req, 0);
        chk("rstmid_late_ack_ready", dm_ready, 0);
        tick();
        chk("rstmid_late_ack_rdata", dm_rdata, 0);
        chk("rstmid_late_ack_ready2", dm_ready, 0);
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        chk("rstmid_then_fetch_req", mem_req, 1);
        chk("rstmid_then_fetch_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; mem_rdata = 32'h00000013;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rstmid_then_fetch_ready", if_ready, 1);
        chk("rstmid_then_fetch_rdata", if_rdata, 32'h00000013);
        if_req = 1'b0;
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        // No ack: after 8 BUSY cycles the fetch completes with err and zero data
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        repeat (7) tick();
        chk("tmo_busy8_req", mem_req, 1);
        tick();
        chk("tmo_if_ready", if_ready, 1);
        chk("tmo_err", err, 1);
        chk("tmo_if_rdata", if_rdata, 0);
        chk("tmo_mem_req", mem_req, 0);
        if_req = 1'b0;
        tick();
        chk("tmo_err_pulse", err, 0);
        tick();
        // Ack in the 8th BUSY cycle wins over the timeout
        if_req = 1'b1; if_addr = 32'h704;
        tick();
        repeat (7) tick();
        mem_ack = 1'b1; mem_rdata = 32'h00000077;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("tmo_ack_if_ready", if_ready, 1);
        chk("tmo_ack_err", err, 0);
        chk("tmo_ack_if_rdata", if_rdata, 32'h00000077);
        if_req = 1'b0;
        tick();
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_mem_arb.md
Name: rv32_mem_arb

Overview:
- Shares one external single-port memory between the core's instruction-fetch port and its data port.
- Grants one requester at a time with one transaction outstanding.
- Each response is returned through a registered ready pulse.
- Drives a core stall signal while any core request is unserved; sits between the rv32 core top and the memory model.

Parameters:
XLEN, 32, address/data width
STREAK_MAX, 4, max consecutive data grants while fetch waits; next grant must go to fetch
TIMEOUT_CYCLES, 255, ack wait limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ready
if_addr  input  XLEN  fetch byte address
if_rdata  output  XLEN  fetched instruction; valid while if_ready
if_ready  output  1  one-cycle fetch completion pulse
dm_req  input  1  data request; held until dm_ready
dm_we  input  1  1=store, 0=load
dm_addr  input  XLEN  data byte address
dm_wdata  input  XLEN  store data
dm_rdata  output  XLEN  load data; valid while dm_ready
dm_ready  output  1  one-cycle data completion pulse
mem_req  output  1  memory request; held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  XLEN  memory byte address
mem_wdata  output  XLEN  memory write data
mem_ack  input  1  memory completes the current request this cycle
mem_rdata  input  XLEN  read data; valid with mem_ack
stall  output  1  (if_req & ~if_ready) | (dm_req & ~dm_ready); combinational
err  output  1  timeout pulse (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset, synchronous active-high: state=IDLE, streak=0, timer=0.
  - All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata, dm_rdata, err.
  - Reset mid-transaction aborts it. mem_req is 0 from the cycle after reset is sampled. No ready pulse is issued for the aborted request.
- FSM has states IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If only one req is high, grant it.
  - If both are high, grant data, unless streak==STREAK_MAX, in which case grant fetch.
  - On a grant, register mem_addr, mem_we (0 for fetch, dm_we for data) and mem_wdata. Go to BUSY_IF or BUSY_DM; mem_req=1 from the next cycle.
- Streak counter:
  - Increments on a data grant made while if_req=1.
  - Resets to 0 on any fetch grant.
  - Saturates at STREAK_MAX.
- BUSY_x:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack: mem_req=0 next cycle. Capture mem_rdata into x_rdata (also on stores; the value is don't-care to the core). Assert x_ready for exactly one cycle, then go to DONE.
- DONE:
  - Lasts one cycle, in which the ready pulse is high.
  - Requests are ignored in this cycle; the requester drops or re-presents req in the following cycle.
  - Then go to IDLE.
- Latency: minimum 3 cycles from req to ready, when ack comes in the first BUSY cycle. Add 1 cycle per extra ack wait cycle.
- if_rdata and dm_rdata hold their last captured value between transactions.
- mem_ack seen in IDLE or DONE is ignored.
- A req that drops before ready is protocol misuse. The transaction still completes and its ready pulse is still issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A timer counts cycles in BUSY_x; it clears on entry.
  - If it reaches TIMEOUT_CYCLES without mem_ack: drop mem_req; set x_rdata to 0; pulse x_ready and err together for one cycle; go to DONE.
  - If mem_ack arrives in the same cycle as the timeout, the ack wins and err=0.
- Undefined: no timer logic; err tied 0; the arbiter waits for ack indefinitely.

Decomposition:
- Shared package rv32_pkg holds:
  - the arbiter state enum (IDLE, BUSY_IF, BUSY_DM, DONE);
  - the XLEN default;
  - the grant-select encoding (GNT_IF=0, GNT_DM=1).
- One sub-module, rv32_arb_prio: combinational grant select plus the registered streak counter. Inputs: if_req, dm_req, idle, STREAK_MAX. Output: grant.
- FSM, datapath registers and timer stay in rv32_mem_arb.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, ack after 2 wait cycles with mem_rdata=0x00500093 -> mem_req high for 3 cycles, mem_addr=0x100, mem_we=0; if_ready pulse at cycle 5 with if_rdata=0x00500093.
- Simultaneous: if_req=1 and dm_req=1 (store 0xDEADBEEF to 0x200) in the same cycle, ack immediate -> data served first with mem_we=1, mem_wdata=0xDEADBEEF; fetch granted after DONE; stall=1 until both ready pulses are seen.
- Starvation: dm_req re-presented continuously with if_req held, STREAK_MAX=4 -> exactly 4 data grants, then a fetch grant; streak returns to 0.
- Reset mid-op: assert reset in BUSY_DM -> next cycle mem_req=0, dm_ready=0, state IDLE; a later ack is ignored.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): fetch with no ack -> after 8 BUSY cycles if_ready=1, err=1, if_rdata=0; ack on the 8th cycle instead -> err=0 and if_rdata=mem_rdata.
- Back-to-back loads 0x10, 0x14 with 1-cycle acks -> consecutive grants separated by the DONE cycle; dm_rdata holds its value between the two.
